fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the pipelined ARM core. It generates the sequential fetch PC and issues requests to instruction memory over a valid/ready handshake, tolerating any response latency. Returned instructions are buffered with their PCs in a DEPTH-entry queue that feeds the decode stage over valid/ready. A redirect from a taken branch or a PC write-back flushes the queue and discards stale in-flight responses.

---
 rtl/fetch_queue_if.sv | 41 ++++
 rtl/fetch_queue.sv | 118 +++++++++++
 tb/tb_fetch_queue.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-queue bus bundle: redirect input, imem request/response channels and the
// decode-side handshake. master = fetch_queue, slave = the surrounding core/memory.
interface fetch_queue_if #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
);
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;

   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [XLEN-1:0] imem_rsp_data;

   logic            dec_valid;
   logic            dec_ready;
   logic [XLEN-1:0] dec_instr;
   logic [XLEN-1:0] dec_pc;

   logic [CW-1:0]   occupancy;

   modport master (
      input  redirect_valid, redirect_pc,
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output dec_valid, dec_instr, dec_pc,
      input  dec_ready,
      output occupancy
   );

   modport slave (
      output redirect_valid, redirect_pc,
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  dec_valid, dec_instr, dec_pc,
      output dec_ready,
      input  occupancy
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential PC generation, credit-limited imem requests,
// in-order response queue feeding decode, and redirect flush with stale-response dropping.
module fetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              CW       = $clog2(DEPTH + 1)
) (
   input logic           clk,
   input logic           rst,
   fetch_queue_if.master bus
);
   localparam int              PW           = $clog2(DEPTH);
   localparam logic [XLEN-1:0] PC_STEP      = XLEN'(4);
   localparam logic [CW+1:0]   CREDIT_LIMIT = (CW + 2)'(DEPTH);

   logic [XLEN-1:0] fetchPcReg, fetchPcNext;
   logic [XLEN-1:0] rspPcReg, rspPcNext;
   logic [CW-1:0]   keepCntReg, keepCntNext;
   logic [CW-1:0]   dropCntReg, dropCntNext;
   logic [CW-1:0]   occCntReg, occCntNext;
   logic [PW-1:0]   rdPtrReg, rdPtrNext;
   logic [PW-1:0]   wrPtrReg, wrPtrNext;

   logic [XLEN-1:0] instrMem [DEPTH];
   logic [XLEN-1:0] pcMem    [DEPTH];

   logic [CW+1:0]   inFlight;
   logic            reqFire;
   logic            deqFire;
   logic            rspDrop;
   logic            rspKeep;
   logic            enq;

   // Queued plus outstanding never exceeds DEPTH, so every kept response has a free slot.
   assign inFlight = {2'b00, occCntReg} + {2'b00, keepCntReg} + {2'b00, dropCntReg};

   assign bus.imem_req_valid = !rst && !bus.redirect_valid && (inFlight < CREDIT_LIMIT);
   assign bus.imem_req_addr  = fetchPcReg;
   assign reqFire            = bus.imem_req_valid && bus.imem_req_ready;

   assign bus.dec_valid = !rst && !bus.redirect_valid && (occCntReg != '0);
   assign bus.dec_instr = instrMem[rdPtrReg];
   assign bus.dec_pc    = pcMem[rdPtrReg];
   assign deqFire       = bus.dec_valid && bus.dec_ready;

   assign bus.occupancy = occCntReg;

   // Stale responses are consumed first; a response with nothing outstanding is ignored.
   assign rspDrop = bus.imem_rsp_valid && (dropCntReg != '0);
   assign rspKeep = bus.imem_rsp_valid && (dropCntReg == '0) && (keepCntReg != '0);
   assign enq     = rspKeep && !bus.redirect_valid && !rst;

   always_comb begin
      fetchPcNext = fetchPcReg;
      rspPcNext   = rspPcReg;
      keepCntNext = keepCntReg;
      dropCntNext = dropCntReg;
      occCntNext  = occCntReg;
      rdPtrNext   = rdPtrReg;
      wrPtrNext   = wrPtrReg;

      if (bus.redirect_valid) begin
         fetchPcNext = bus.redirect_pc;
         rspPcNext   = bus.redirect_pc;
         keepCntNext = '0;
         occCntNext  = '0;
         rdPtrNext   = '0;
         wrPtrNext   = '0;
         // Everything still outstanding becomes stale; one may be retiring right now.
         if (bus.imem_rsp_valid && ((dropCntReg != '0) || (keepCntReg != '0)))
            dropCntNext = dropCntReg + keepCntReg - CW'(1);
         else
            dropCntNext = dropCntReg + keepCntReg;
      end else begin
         if (reqFire)
            fetchPcNext = fetchPcReg + PC_STEP;
         keepCntNext = keepCntReg + CW'(reqFire) - CW'(rspKeep);
         if (rspDrop)
            dropCntNext = dropCntReg - CW'(1);
         if (rspKeep) begin
            rspPcNext = rspPcReg + PC_STEP;
            wrPtrNext = wrPtrReg + PW'(1);
         end
         if (deqFire)
            rdPtrNext = rdPtrReg + PW'(1);
         occCntNext = occCntReg + CW'(rspKeep) - CW'(deqFire);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetchPcReg <= RESET_PC;
         rspPcReg   <= RESET_PC;
         keepCntReg <= '0;
         dropCntReg <= '0;
         occCntReg  <= '0;
         rdPtrReg   <= '0;
         wrPtrReg   <= '0;
      end else begin
         fetchPcReg <= fetchPcNext;
         rspPcReg   <= rspPcNext;
         keepCntReg <= keepCntNext;
         dropCntReg <= dropCntNext;
         occCntReg  <= occCntNext;
         rdPtrReg   <= rdPtrNext;
         wrPtrReg   <= wrPtrNext;
      end
   end

   // Entry storage carries no reset; contents only matter while occupancy covers them.
   always_ff @(posedge clk) begin
      if (enq) begin
         instrMem[wrPtrReg] <= bus.imem_rsp_data;
         pcMem[wrPtrReg]    <= rspPcReg;
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: latency-programmable imem model plus a PC scoreboard
// that is filled at each accepted request and drained at each decode handshake.
module tb_fetch_queue;
   localparam int              XLEN     = 32;
   localparam int              DEPTH    = 4;
   localparam logic [XLEN-1:0] RESET_PC = '0;

   typedef struct {
      logic [XLEN-1:0] addr;
      int              due;
   } flight_t;

   logic clk = 1'b0;
   logic rst;

   int checks      = 0;
   int errors      = 0;
   int cycle       = 0;
   int lat         = 1;
   int acceptCount = 0;

   logic [XLEN-1:0] expReqPc = RESET_PC;
   logic [XLEN-1:0] expQ[$];
   flight_t         inflight[$];

   always #5 clk = ~clk;

   fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

   fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   function automatic logic [XLEN-1:0] instrOf(input logic [XLEN-1:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
   endfunction

   task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic waitReq(input string tag, input logic [XLEN-1:0] addr);
      logic            seen = 1'b0;
      logic [XLEN-1:0] got  = '0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.imem_req_valid && bus.imem_req_ready) begin
            seen = 1'b1;
            got  = bus.imem_req_addr;
            break;
         end
      end
      chk({tag, "_seen"}, XLEN'(seen), XLEN'(1));
      chk(tag, got, addr);
   endtask

   // imem model: responses return in order, each no earlier than its due cycle.
   initial begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      forever begin
         @(posedge clk);
         cycle++;
         #1;
         if (inflight.size() != 0 && inflight[0].due <= cycle) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = instrOf(inflight[0].addr);
            void'(inflight.pop_front());
         end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
         end
      end
   end

   // Monitor: request addresses must run sequentially from the last restart point and
   // decode must deliver exactly the kept requests, in order, with matching data.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            expQ.delete();
            inflight.delete();
            expReqPc = RESET_PC;
         end else if (bus.redirect_valid) begin
            chk("redir_no_req", XLEN'(bus.imem_req_valid), XLEN'(0));
            chk("redir_no_dec", XLEN'(bus.dec_valid), XLEN'(0));
            expQ.delete();
            expReqPc = bus.redirect_pc;
         end else begin
            if (bus.dec_valid && bus.dec_ready) begin
               checks++;
               assert (expQ.size() != 0) else begin
                  errors++;
                  $error("FAIL dec_extra: observed pc %h expected no entry", bus.dec_pc);
               end
               if (expQ.size() != 0) begin
                  chk("dec_pc", bus.dec_pc, expQ[0]);
                  chk("dec_instr", bus.dec_instr, instrOf(expQ[0]));
                  void'(expQ.pop_front());
               end
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
               chk("req_addr", bus.imem_req_addr, expReqPc);
               expQ.push_back(expReqPc);
               inflight.push_back('{addr: bus.imem_req_addr, due: cycle + lat});
               expReqPc    = expReqPc + 32'd4;
               acceptCount = acceptCount + 1;
            end
         end
      end
   end

   initial begin
      logic seen;
      rst                = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.imem_req_ready = 1'b1;
      bus.dec_ready      = 1'b1;

      // Reset state
      step(2);
      @(negedge clk);
      chk("rst_req_valid", XLEN'(bus.imem_req_valid), XLEN'(0));
      chk("rst_dec_valid", XLEN'(bus.dec_valid), XLEN'(0));
      chk("rst_occupancy", XLEN'(bus.occupancy), XLEN'(0));

      // Streaming, L=1: first accept, decode two cycles later, then one per cycle
      step(1);
      rst = 1'b0;
      @(negedge clk);
      chk("stream_first_req", XLEN'(bus.imem_req_valid), XLEN'(1));
      chk("stream_first_addr", bus.imem_req_addr, RESET_PC);
      step(1);
      @(negedge clk);
      chk("stream_no_bypass", XLEN'(bus.dec_valid), XLEN'(0));
      step(1);
      @(negedge clk);
      chk("stream_dec_valid", XLEN'(bus.dec_valid), XLEN'(1));
      chk("stream_dec_pc0", bus.dec_pc, RESET_PC);
      for (int i = 0; i < 8; i++) begin
         step(1);
         @(negedge clk);
         chk("stream_tput", XLEN'(bus.dec_valid), XLEN'(1));
      end

      // Backpressure: restart at 0 with decode stalled
      step(1);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0;
      bus.dec_ready      = 1'b0;
      acceptCount        = 0;
      step(1);
      bus.redirect_valid = 1'b0;
      step(8);
      chk("bp_accepts", XLEN'(acceptCount), XLEN'(DEPTH));
      @(negedge clk);
      chk("bp_occupancy", XLEN'(bus.occupancy), XLEN'(DEPTH));
      chk("bp_req_blocked", XLEN'(bus.imem_req_valid), XLEN'(0));
      step(1);
      bus.dec_ready = 1'b1;
      @(negedge clk);
      chk("bp_full_until_deq", XLEN'(bus.imem_req_valid), XLEN'(0));
      step(1);
      @(negedge clk);
      chk("bp_resume_req", XLEN'(bus.imem_req_valid), XLEN'(1));
      chk("bp_resume_addr", bus.imem_req_addr, 32'h10);

      // Request stall at 0x8
      step(10);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0;
      acceptCount        = 0;
      step(1);
      bus.redirect_valid = 1'b0;
      step(2);
      bus.imem_req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_valid", XLEN'(bus.imem_req_valid), XLEN'(1));
         chk("stall_addr", bus.imem_req_addr, 32'h8);
         step(1);
      end
      bus.imem_req_ready = 1'b1;
      @(negedge clk);
      chk("stall_release_addr", bus.imem_req_addr, 32'h8);
      step(1);
      chk("stall_accepts", XLEN'(acceptCount), XLEN'(3));
      @(negedge clk);
      chk("stall_next_addr", bus.imem_req_addr, 32'hC);

      // Flush with late responses (L=3) combined with rsp + dec_ready in the redirect cycle
      step(1);
      bus.imem_req_ready = 1'b0;
      step(8);
      lat                = 3;
      bus.dec_ready      = 1'b0;
      bus.imem_req_ready = 1'b1;
      step(5);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h100;
      bus.dec_ready      = 1'b1;
      @(negedge clk);
      chk("flush_pre_occupancy", XLEN'(bus.occupancy), XLEN'(2));
      chk("flush_rsp_same_cycle", XLEN'(bus.imem_rsp_valid), XLEN'(1));
      chk("flush_no_deq", XLEN'(bus.dec_valid), XLEN'(0));
      step(1);
      bus.redirect_valid = 1'b0;
      @(negedge clk);
      chk("flush_occupancy", XLEN'(bus.occupancy), XLEN'(0));
      chk("flush_drop_cnt", XLEN'(dut.dropCntReg), XLEN'(1));
      chk("flush_first_req", bus.imem_req_addr, 32'h100);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = bus.dec_valid;
      end
      chk("flush_dec_seen", XLEN'(seen), XLEN'(1));
      chk("flush_dec_pc", bus.dec_pc, 32'h100);
      chk("flush_dec_instr", bus.dec_instr, instrOf(32'h100));

      // PC wrap, then reset mid-stream
      step(3);
      lat                = 1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'hFFFF_FFFC;
      step(1);
      bus.redirect_valid = 1'b0;
      waitReq("wrap_a", 32'hFFFF_FFFC);
      waitReq("wrap_b", 32'h0);
      waitReq("wrap_c", 32'h4);
      step(4);
      rst = 1'b1;
      step(1);
      @(negedge clk);
      chk("midrst_occupancy", XLEN'(bus.occupancy), XLEN'(0));
      chk("midrst_req_valid", XLEN'(bus.imem_req_valid), XLEN'(0));
      chk("midrst_dec_valid", XLEN'(bus.dec_valid), XLEN'(0));
      chk("midrst_keep_cnt", XLEN'(dut.keepCntReg), XLEN'(0));
      chk("midrst_drop_cnt", XLEN'(dut.dropCntReg), XLEN'(0));
      step(1);
      rst = 1'b0;
      waitReq("rst_restart", RESET_PC);
      step(10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
